// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and result flags for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_AND  = 1;
  localparam int unsigned OP_OR   = 2;
  localparam int unsigned OP_NOTB = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_NEGB = 6;
  localparam int unsigned OP_ROL  = 7;
  localparam int unsigned OP_ROR  = 8;
  localparam int unsigned OP_SHL  = 9;
  localparam int unsigned OP_SHR  = 10;
  localparam int unsigned OP_SHRA = 11;
  localparam int unsigned OP_ADD  = 12;
  localparam int unsigned OP_SUB  = 13;
  localparam int unsigned OP_MUL  = 14;
  localparam int unsigned OP_DIV  = 15;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} alu_state_e;

  typedef enum logic {MD_MUL, MD_DIV} md_op_e;

  typedef struct packed {
    logic ovf;
    logic dbz;
    logic bad_op;
  } alu_flags_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiplier (radix-2 Booth, W steps) and divider
// (non-restoring on magnitudes, W steps plus one correction/sign cycle).
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           i_start,
  input  md_op_e         i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_result
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_MUL = CW'(W - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(W);

  md_op_e        r_op;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_acc;
  logic [W-1:0]  r_q;
  logic          r_qm1;
  logic [W-1:0]  r_m;
  logic [W+1:0]  r_rem;
  logic          r_neg_q;
  logic          r_neg_r;

  logic          w_last;
  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;
  logic [W:0]    w_booth_sum;
  logic [W:0]    w_acc_next;
  logic [W-1:0]  w_mq_next;
  logic [W+1:0]  w_shifted;
  logic [W+1:0]  w_rem_step;
  logic [W-1:0]  w_dq_next;
  logic [W-1:0]  w_rem_fix;
  logic [W-1:0]  w_quo_s;
  logic [W-1:0]  w_rem_s;

  assign w_last  = (r_op == MD_MUL) ? (r_cnt == LAST_MUL) : (r_cnt == LAST_DIV);
  assign o_busy  = r_busy;
  assign o_done  = r_busy & w_last;
  assign w_abs_a = i_a[W-1] ? -i_a : i_a;
  assign w_abs_b = i_b[W-1] ? -i_b : i_b;

  // One extra accumulator bit keeps -M representable for the most negative multiplicand.
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_acc + {r_m[W-1], r_m};
      2'b10:   w_booth_sum = r_acc - {r_m[W-1], r_m};
      default: w_booth_sum = r_acc;
    endcase
  end

  assign w_acc_next = {w_booth_sum[W], w_booth_sum[W:1]};
  assign w_mq_next  = {w_booth_sum[0], r_q[W-1:1]};

  assign w_shifted  = {r_rem[W:0], r_q[W-1]};
  assign w_rem_step = r_rem[W+1] ? (w_shifted + {2'b00, r_m}) : (w_shifted - {2'b00, r_m});
  assign w_dq_next  = {r_q[W-2:0], ~w_rem_step[W+1]};

  // The final remainder lies in [0, divisor), so only its low W bits matter.
  assign w_rem_fix = r_rem[W+1] ? (r_rem[W-1:0] + r_m) : r_rem[W-1:0];
  assign w_quo_s   = r_neg_q ? -r_q : r_q;
  assign w_rem_s   = r_neg_r ? -w_rem_fix : w_rem_fix;

  assign o_result = (r_op == MD_MUL) ? {w_acc_next[W-1:0], w_mq_next} : {w_rem_s, w_quo_s};

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_busy  <= 1'b0;
      r_op    <= MD_MUL;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_op   <= i_op;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_qm1  <= 1'b0;
      r_rem  <= '0;
      if (i_op == MD_MUL) begin
        r_m     <= i_a;
        r_q     <= i_b;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_m     <= w_abs_b;
        r_q     <= w_abs_a;
        r_neg_q <= i_a[W-1] ^ i_b[W-1];
        r_neg_r <= i_a[W-1];
      end
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
      if (r_op == MD_MUL) begin
        r_acc <= w_acc_next;
        r_q   <= w_mq_next;
        r_qm1 <= r_q[0];
      end else if (!w_last) begin
        r_rem <= w_rem_step;
        r_q   <= w_dq_next;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic, shift and
// add/sub ops, plus iterative signed multiply and divide via seq_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [SEL_WIDTH-1:0]  ALU_Sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ZHigh,
  output logic [DATA_WIDTH-1:0] ZLow,
  output logic                  ovf,
  output logic                  dbz,
  output logic                  bad_op
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);

  alu_state_e           r_state;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [W-1:0]         r_zhigh;
  logic [W-1:0]         r_zlow;
  alu_flags_t           r_flags;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_md_start;
  md_op_e               w_md_op;
  logic                 w_md_busy;
  logic                 w_md_done;
  logic [2*W-1:0]       w_md_result;
  logic [SHW-1:0]       w_sh;
  logic [W-1:0]         w_sum;
  logic [W-1:0]         w_diff;
  logic [W-1:0]         w_exec_hi;
  logic [W-1:0]         w_exec_lo;
  alu_flags_t           w_exec_flags;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ZHigh     = r_zhigh;
  assign ZLow      = r_zlow;
  assign ovf       = r_flags.ovf;
  assign dbz       = r_flags.dbz;
  assign bad_op    = r_flags.bad_op;

  assign w_accept   = in_valid & in_ready;
  assign w_is_mul   = (ALU_Sel == SEL_WIDTH'(OP_MUL));
  assign w_is_div   = (ALU_Sel == SEL_WIDTH'(OP_DIV)) && (B != '0);
  assign w_md_start = w_accept & (w_is_mul | w_is_div);
  assign w_md_op    = w_is_mul ? MD_MUL : MD_DIV;

  // The iterative unit captures operands straight from the ports on the accept edge.
  seq_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .clr      (clr),
    .i_start  (w_md_start),
    .i_op     (w_md_op),
    .i_a      (A),
    .i_b      (B),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign w_sh   = r_b[SHW-1:0];
  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;

  always_comb begin
    w_exec_hi    = '0;
    w_exec_lo    = '0;
    w_exec_flags = '0;
    case (r_sel)
      SEL_WIDTH'(OP_AND):  w_exec_lo = r_a & r_b;
      SEL_WIDTH'(OP_OR):   w_exec_lo = r_a | r_b;
      SEL_WIDTH'(OP_NOTB): w_exec_lo = ~r_b;
      SEL_WIDTH'(OP_XOR):  w_exec_lo = r_a ^ r_b;
      SEL_WIDTH'(OP_NOR):  w_exec_lo = ~(r_a | r_b);
      SEL_WIDTH'(OP_NEGB): w_exec_lo = -r_b;
      SEL_WIDTH'(OP_ROL):  w_exec_lo = (r_a << w_sh) | (r_a >> (W - int'(w_sh)));
      SEL_WIDTH'(OP_ROR):  w_exec_lo = (r_a >> w_sh) | (r_a << (W - int'(w_sh)));
      SEL_WIDTH'(OP_SHL):  w_exec_lo = r_a << w_sh;
      SEL_WIDTH'(OP_SHR):  w_exec_lo = r_a >> w_sh;
      SEL_WIDTH'(OP_SHRA): w_exec_lo = $signed(r_a) >>> w_sh;
      SEL_WIDTH'(OP_ADD): begin
        w_exec_lo        = w_sum;
        w_exec_flags.ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      SEL_WIDTH'(OP_SUB): begin
        w_exec_lo        = w_diff;
        w_exec_flags.ovf = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
      end
      // Division only lands here when the divisor was zero.
      SEL_WIDTH'(OP_DIV): begin
        w_exec_hi        = r_a;
        w_exec_lo        = '1;
        w_exec_flags.dbz = 1'b1;
      end
      default: w_exec_flags.bad_op = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_zhigh <= '0;
      r_zlow  <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_sel <= ALU_Sel;
            if (w_is_mul)      r_state <= MUL;
            else if (w_is_div) r_state <= DIV;
            else               r_state <= EXEC;
          end
        end
        EXEC: begin
          r_zhigh <= w_exec_hi;
          r_zlow  <= w_exec_lo;
          r_flags <= w_exec_flags;
          r_state <= DONE;
        end
        MUL, DIV: begin
          if (w_md_done) begin
            r_zhigh <= w_md_result[2*W-1:W];
            r_zlow  <= w_md_result[W-1:0];
            r_flags <= '0;
            r_state <= DONE;
          end else if (!w_md_busy) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
